s2c_pkt_serializer: RTL and testbench
=====================================

S2C_PKT_SERIALIZER -- requirements
Module: s2c_pkt_serializer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: number of 32-bit payload words per packet (matches S2CIF_DATA_SIZE).
REQ-002 SHALL have parameter FN_END, default 2: function code marking end-of-test.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port pkt_valid  input  1  upstream packet available.
REQ-006 SHALL have port pkt_ready  output  1  serializer can accept a packet.
REQ-007 SHALL have port pkt_id  input  32  packet id.
REQ-008 SHALL have port pkt_fn  input  32  function code.
REQ-009 SHALL have port pkt_ret  input  32  signed return status from the host side.
REQ-010 SHALL have port pkt_data  input  32*DATA_SIZE  payload; word k at bits [32k+31:32k].
REQ-011 SHALL have port out_valid  output  1  stream word valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts word.
REQ-013 SHALL have port out_data  output  32  stream word.
REQ-014 SHALL have port out_sop  output  1  first word of packet.
REQ-015 SHALL have port out_last  output  1  final word of packet.
REQ-016 SHALL have port end_seen  output  1  sticky: an FN_END packet has been fully emitted.
REQ-017 SHALL have port pkt_count  output  16  packets fully emitted.
REQ-018 SHALL have port err_count  output  16  packets emitted with pkt_ret != 0.

Function
REQ-019 SHALL implement an FSM with states IDLE, HDR_ID, HDR_FN, DATA, HALT.
REQ-020 pkt_ready SHALL be 1 only in IDLE; a packet is accepted on pkt_valid && pkt_ready and all inputs are captured into registers that cycle.
REQ-021 On acceptance the FSM SHALL go to HDR_ID; out_valid rises the next cycle (1-cycle latency) with out_data = id, out_sop = 1.
REQ-022 HDR_FN word SHALL be {fn[15:0], len[15:0]}, where len = DATA_SIZE if ret == 0, else 0.
REQ-023 DATA state SHALL emit captured words 0..DATA_SIZE-1 in ascending order using a beat counter of width clog2(DATA_SIZE)+1.
REQ-024 Words SHALL advance only on out_valid && out_ready; out_data/out_sop/out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 out_last SHALL be 1 on the HDR_FN word when len == 0, else on data word DATA_SIZE-1.
REQ-026 On the last-word handshake pkt_count SHALL increment; err_count SHALL increment in the same cycle if ret != 0; both saturate at 16'hFFFF.
REQ-027 After the last word, the FSM SHALL return to IDLE, or enter HALT if captured fn == FN_END.
REQ-028 Entering HALT SHALL set end_seen = 1; HALT is left only by reset; pkt_ready = 0 and out_valid = 0 in HALT.
REQ-029 pkt_valid while not ready SHALL be ignored; no packet is accepted in the same cycle as a last-word handshake (back-to-back minimum gap: 1 IDLE cycle).
REQ-030 An FN_END packet with ret != 0 SHALL still emit a header-only packet, count as an error, and halt.

Reset
REQ-031 rst SHALL force state = IDLE, out_valid = 0, out_sop = 0, out_last = 0, out_data = 0, end_seen = 0, pkt_count = 0, err_count = 0, beat counter = 0.
REQ-032 rst asserted mid-packet SHALL abort it with no count update; the next cycle after rst deasserts pkt_ready = 1.

Structure
REQ-033 Packet typedef (id, fn, ret, data array), DATA_SIZE and FN_END constants, and FSM state enum SHALL live in shared package s2c_pkg.
REQ-034 Word selection SHALL be a sub-module s2c_word_mux (captured payload + beat index -> 32-bit word).

Verification
REQ-035 Normal: id=5, fn=7, ret=0, data=1..8, out_ready=1 -> 10 words: 5 (sop), 0x00070008, 1..8 (last on 8); pkt_count=1.
REQ-036 Error: id=3, fn=1, ret=-1 -> 2 words: 3 (sop), 0x00010000 (last); err_count=1, pkt_count=1.
REQ-037 Backpressure: out_ready toggled 1,0,0,1 during data -> each word held while stalled, no loss/duplication, order preserved.
REQ-038 End: id=0, fn=2, ret=0 -> full packet, end_seen=1, pkt_ready=0; further pkt_valid ignored for 20 cycles.
REQ-039 Mid-packet reset: rst pulse at data word 3 -> outputs and counters zero, pkt_ready=1 next cycle, following packet emitted intact.
REQ-040 Back-to-back: pkt_valid held high with two packets -> second accepted one IDLE cycle after first out_last handshake; pkt_count=2.

Source files
------------

// File: rtl/s2c_pkg.sv
// Shared types and constants for the S2C packet serializer.
package s2c_pkg;

    // Default payload length in 32-bit words and the end-of-test function code.
    localparam int S2C_DATA_SIZE = 8;
    localparam int S2C_FN_END    = 2;

    // Header fields captured with every packet.
    typedef struct packed {
        logic        [31:0] id;
        logic        [31:0] fn;
        logic signed [31:0] ret;
    } s2c_hdr_t;

    // Full packet: header plus payload array (element k is payload word k).
    typedef struct packed {
        s2c_hdr_t                         hdr;
        logic [S2C_DATA_SIZE-1:0][31:0]   data;
    } s2c_pkt_t;

    // Serializer FSM states.
    typedef enum logic [2:0] {
        IDLE,
        HDR_ID,
        HDR_FN,
        DATA,
        HALT
    } s2c_state_t;

    // Payload length advertised in the function word: a failed request carries no data.
    function automatic logic [15:0] s2c_len(input logic signed [31:0] ret, input int data_size);
        return (ret == 0) ? 16'(data_size) : 16'd0;
    endfunction

endpackage

// File: rtl/s2c_word_mux.sv
// Selects one 32-bit payload word from the captured packet by beat index.
module s2c_word_mux
    import s2c_pkg::*;
#(
    parameter int DATA_SIZE = S2C_DATA_SIZE,
    parameter int BW        = $clog2(DATA_SIZE) + 1
) (
    input  logic [32*DATA_SIZE-1:0] payload,
    input  logic [BW-1:0]           beat,
    output logic [31:0]             word
);

    // Decode the beat index into a word select; out-of-range beats yield zero.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        word = '0;
        for (int k = 0; k < DATA_SIZE; k++) begin
            if (beat == BW'(k)) begin
                word = payload[32*k +: 32];
            end
        end
    end

endmodule

// File: rtl/s2c_pkt_serializer.sv
// Serializes a captured S2C packet into a 32-bit valid/ready word stream:
// id word, {fn[15:0], len} word, then len payload words. Counts emitted
// packets and error packets, and halts after an end-of-test packet.
module s2c_pkt_serializer
    import s2c_pkg::*;
#(
    parameter int DATA_SIZE = S2C_DATA_SIZE,
    parameter int FN_END    = S2C_FN_END
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic [31:0]             pkt_id,
    input  logic [31:0]             pkt_fn,
    input  logic signed [31:0]      pkt_ret,
    input  logic [32*DATA_SIZE-1:0] pkt_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic                    out_sop,
    output logic                    out_last,
    output logic                    end_seen,
    output logic [15:0]             pkt_count,
    output logic [15:0]             err_count
);

    localparam int            BW        = $clog2(DATA_SIZE) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(DATA_SIZE - 1);

    s2c_state_t              state;
    s2c_state_t              state_next;
    s2c_state_t              done_state;
    logic [BW-1:0]           beat;
    logic [BW-1:0]           beat_next;
    s2c_hdr_t                hdr;
    logic [32*DATA_SIZE-1:0] payload;
    logic [15:0]             len;
    logic [31:0]             data_word;
    logic                    accept;
    logic                    last_hs;

    s2c_word_mux #(
        .DATA_SIZE (DATA_SIZE),
        .BW        (BW)
    ) u_word_mux (
        .payload (payload),
        .beat    (beat),
        .word    (data_word)
    );

    // Next-state, beat and stream output decode from the registered state.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        pkt_ready  = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_sop    = 1'b0;
        out_last   = 1'b0;
        accept     = 1'b0;
        len        = s2c_len(hdr.ret, DATA_SIZE);
        done_state = (hdr.fn == 32'(FN_END)) ? HALT : IDLE;

        case (state)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    accept     = 1'b1;
                    state_next = HDR_ID;
                end
            end
            HDR_ID: begin
                out_valid = 1'b1;
                out_data  = hdr.id;
                out_sop   = 1'b1;
                if (out_ready) begin
                    state_next = HDR_FN;
                end
            end
            HDR_FN: begin
                out_valid = 1'b1;
                out_data  = {hdr.fn[15:0], len};
                out_last  = (len == 16'd0);
                if (out_ready) begin
                    beat_next  = '0;
                    state_next = (len == 16'd0) ? done_state : DATA;
                end
            end
            DATA: begin
                out_valid = 1'b1;
                out_data  = data_word;
                out_last  = (beat == LAST_BEAT);
                if (out_ready) begin
                    if (beat == LAST_BEAT) begin
                        beat_next  = '0;
                        state_next = done_state;
                    end else begin
                        beat_next = beat + BW'(1);
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        last_hs = out_valid && out_ready && out_last;
    end

    // State, beat counter, packet/error counters and the sticky end flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            end_seen  <= 1'b0;
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            beat  <= beat_next;
            if (last_hs) begin
                if (pkt_count != 16'hFFFF) begin
                    pkt_count <= pkt_count + 16'd1;
                end
                if (hdr.ret != 0 && err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
            if (state_next == HALT) begin
                end_seen <= 1'b1;
            end
        end
    end

    // Packet capture on acceptance.
    always_ff @(posedge clk) begin
        // NOTE: the capture registers are deliberately not reset; they are only read after an accept loads them.
        if (accept) begin
            hdr.id  <= pkt_id;
            hdr.fn  <= pkt_fn;
            hdr.ret <= pkt_ret;
            payload <= pkt_data;
        end
    end

endmodule

// File: tb/tb_s2c_pkt_serializer.sv
// Self-checking bench for s2c_pkt_serializer: a stream monitor collects every
// handshaken word and a packet-level model lists the words each packet must produce.
module tb_s2c_pkt_serializer;
    import s2c_pkg::*;

    localparam int          DS     = S2C_DATA_SIZE;
    localparam logic [31:0] FN_END = 32'd2;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        last;
    } word_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               pkt_valid;
    logic               pkt_ready;
    logic [31:0]        pkt_id;
    logic [31:0]        pkt_fn;
    logic signed [31:0] pkt_ret;
    logic [32*DS-1:0]   pkt_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic               out_sop;
    logic               out_last;
    logic               end_seen;
    logic [15:0]        pkt_count;
    logic [15:0]        err_count;

    int    tests_run    = 0;
    int    tests_failed = 0;
    int    cyc          = 0;
    word_t got_q[$];
    word_t exp_q[$];
    int    last_cyc_q[$];
    int    acc_cyc_q[$];
    int    exp_pkts;
    int    exp_errs;
    logic  exp_end;

    always #5 clk = ~clk;

    // Cycle index used to time-stamp handshakes.
    always @(posedge clk) cyc <= cyc + 1;

    s2c_pkt_serializer #(
        .DATA_SIZE (DS),
        .FN_END    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_id    (pkt_id),
        .pkt_fn    (pkt_fn),
        .pkt_ret   (pkt_ret),
        .pkt_data  (pkt_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_last  (out_last),
        .end_seen  (end_seen),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    // Monitor: record handshakes that will complete on the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_q.push_back({out_data, out_sop, out_last});
                if (out_last) last_cyc_q.push_back(cyc);
            end
            if (pkt_valid && pkt_ready) acc_cyc_q.push_back(cyc);
        end
    end

    // Reference model: the word list a packet must produce, plus counter effects.
    function automatic void model_pkt(input s2c_pkt_t p);
        logic [31:0] words[$];
        logic [15:0] len;
        len = (p.hdr.ret == 0) ? 16'(DS) : 16'd0;
        words.push_back(p.hdr.id);
        words.push_back({p.hdr.fn[15:0], len});
        if (p.hdr.ret == 0) begin
            for (int k = 0; k < DS; k++) words.push_back(p.data[k]);
        end
        foreach (words[i]) exp_q.push_back({words[i], (i == 0), (i == words.size() - 1)});
        exp_pkts++;
        if (p.hdr.ret != 0) exp_errs++;
        if (p.hdr.fn == FN_END) exp_end = 1'b1;
    endfunction

    function automatic s2c_pkt_t rand_pkt(input bit ok_ret);
        s2c_pkt_t p;
        p.hdr.id  = $urandom;
        p.hdr.fn  = $urandom;
        if (p.hdr.fn == FN_END) p.hdr.fn = 32'd3;
        p.hdr.ret = ok_ret ? 32'sd0 : signed'($urandom | 32'd1);
        for (int k = 0; k < DS; k++) p.data[k] = $urandom;
        return p;
    endfunction

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
        last_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        pkt_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_queues();
        exp_pkts = 0;
        exp_errs = 0;
        exp_end  = 1'b0;
    endtask

    // Present a packet until accepted; ok stays 0 if the budget expires.
    task automatic offer(input s2c_pkt_t p, output bit ok);
        pkt_id    = p.hdr.id;
        pkt_fn    = p.hdr.fn;
        pkt_ret   = p.hdr.ret;
        pkt_data  = p.data;
        pkt_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (pkt_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
    endtask

    // Run cycles until n words were collected (mode 0: ready high, 1: random ready).
    task automatic drain(input int n, input int mode);
        for (int i = 0; i < 600 && got_q.size() < n; i++) begin
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b sop=%b last=%b data=%h, expected all zero",
                     out_valid, out_sop, out_last, out_data);
        end
        tests_run++;
        if (pkt_count !== 16'd0 || err_count !== 16'd0 || end_seen !== 1'b0 || pkt_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_status: got pkt=%0d err=%0d end=%b ready=%b, expected 0 0 0 1",
                     pkt_count, err_count, end_seen, pkt_ready);
        end
    endtask

    task automatic test_normal();
        s2c_pkt_t p;
        bit       ok;
        clear_queues();
        p.hdr.id  = 32'd5;
        p.hdr.fn  = 32'd7;
        p.hdr.ret = 32'sd0;
        for (int k = 0; k < DS; k++) p.data[k] = 32'(k + 1);
        model_pkt(p);
        offer(p, ok);
        tests_run++;
        if (!ok || out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== 32'd5) begin
            tests_failed++;
            $display("FAIL normal_latency: got accepted=%b valid=%b sop=%b data=%h, expected 1 1 1 00000005",
                     ok, out_valid, out_sop, out_data);
        end
        drain(exp_q.size(), 0);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL normal_len: got %0d words, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL normal_word%0d: got %h/%b/%b, expected %h/%b/%b", i, got_q[i].data,
                         got_q[i].sop, got_q[i].last, exp_q[i].data, exp_q[i].sop, exp_q[i].last);
            end
        end
        tests_run++;
        if (pkt_count !== 16'(exp_pkts) || err_count !== 16'(exp_errs) || end_seen !== exp_end) begin
            tests_failed++;
            $display("FAIL normal_counts: got pkt=%0d err=%0d end=%b, expected %0d %0d %b",
                     pkt_count, err_count, end_seen, exp_pkts, exp_errs, exp_end);
        end
    endtask

    task automatic test_error();
        s2c_pkt_t p;
        bit       ok;
        clear_queues();
        p         = rand_pkt(1'b0);
        p.hdr.id  = 32'd3;
        p.hdr.fn  = 32'd1;
        p.hdr.ret = -32'sd1;
        model_pkt(p);
        offer(p, ok);
        drain(exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (!ok || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL error_len: got accepted=%b words=%0d, expected 1 %0d", ok, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL error_word%0d: got %h/%b/%b, expected %h/%b/%b", i, got_q[i].data,
                         got_q[i].sop, got_q[i].last, exp_q[i].data, exp_q[i].sop, exp_q[i].last);
            end
        end
        tests_run++;
        if (pkt_count !== 16'(exp_pkts) || err_count !== 16'(exp_errs) || end_seen !== exp_end) begin
            tests_failed++;
            $display("FAIL error_counts: got pkt=%0d err=%0d end=%b, expected %0d %0d %b",
                     pkt_count, err_count, end_seen, exp_pkts, exp_errs, exp_end);
        end
    endtask

    task automatic test_backpressure();
        s2c_pkt_t   p;
        bit         ok;
        bit         stalled;
        word_t      held;
        logic [3:0] pat;
        clear_queues();
        pat     = 4'b1001;
        stalled = 1'b0;
        held    = '0;
        p       = rand_pkt(1'b1);
        model_pkt(p);
        offer(p, ok);
        for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) begin
            if (stalled) begin
                tests_run++;
                if (out_valid !== 1'b1 || {out_data, out_sop, out_last} !== held) begin
                    tests_failed++;
                    $display("FAIL bp_hold: got valid=%b %h/%b/%b, expected 1 %h/%b/%b", out_valid,
                             out_data, out_sop, out_last, held.data, held.sop, held.last);
                end
            end
            out_ready = pat[i % 4];
            stalled   = out_valid && !out_ready;
            held      = {out_data, out_sop, out_last};
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        tests_run++;
        if (!ok || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL bp_len: got accepted=%b words=%0d, expected 1 %0d", ok, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL bp_word%0d: got %h/%b/%b, expected %h/%b/%b", i, got_q[i].data,
                         got_q[i].sop, got_q[i].last, exp_q[i].data, exp_q[i].sop, exp_q[i].last);
            end
        end
        tests_run++;
        if (pkt_count !== 16'(exp_pkts) || err_count !== 16'(exp_errs)) begin
            tests_failed++;
            $display("FAIL bp_counts: got pkt=%0d err=%0d, expected %0d %0d",
                     pkt_count, err_count, exp_pkts, exp_errs);
        end
    endtask

    task automatic test_random();
        s2c_pkt_t p;
        bit       ok;
        int       not_taken;
        clear_queues();
        not_taken = 0;
        for (int n = 0; n < 25; n++) begin
            p = rand_pkt(1'($urandom_range(0, 1)));
            model_pkt(p);
            offer(p, ok);
            if (!ok) not_taken++;
            drain(exp_q.size(), 1);
        end
        tests_run++;
        if (not_taken != 0 || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL random_len: got refused=%0d words=%0d, expected 0 %0d",
                     not_taken, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL random_word%0d: got %h/%b/%b, expected %h/%b/%b", i, got_q[i].data,
                         got_q[i].sop, got_q[i].last, exp_q[i].data, exp_q[i].sop, exp_q[i].last);
            end
        end
        tests_run++;
        if (pkt_count !== 16'(exp_pkts) || err_count !== 16'(exp_errs) || end_seen !== exp_end) begin
            tests_failed++;
            $display("FAIL random_counts: got pkt=%0d err=%0d end=%b, expected %0d %0d %b",
                     pkt_count, err_count, end_seen, exp_pkts, exp_errs, exp_end);
        end
    endtask

    task automatic test_back_to_back();
        s2c_pkt_t p1;
        s2c_pkt_t p2;
        bit       ok1;
        bit       ok2;
        int       gap;
        apply_reset();
        p1 = rand_pkt(1'b1);
        p2 = rand_pkt(1'b1);
        model_pkt(p1);
        model_pkt(p2);
        fork
            begin
                offer(p1, ok1);
                offer(p2, ok2);
            end
            drain(exp_q.size(), 0);
        join
        gap = (acc_cyc_q.size() == 2 && last_cyc_q.size() >= 1) ? acc_cyc_q[1] - last_cyc_q[0] : -1;
        tests_run++;
        if (!ok1 || !ok2 || gap != 1) begin
            tests_failed++;
            $display("FAIL b2b_gap: got accepted=%b%b gap=%0d cycles, expected 11 1", ok1, ok2, gap);
        end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL b2b_len: got %0d words, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL b2b_word%0d: got %h/%b/%b, expected %h/%b/%b", i, got_q[i].data,
                         got_q[i].sop, got_q[i].last, exp_q[i].data, exp_q[i].sop, exp_q[i].last);
            end
        end
        tests_run++;
        if (pkt_count !== 16'd2 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL b2b_counts: got pkt=%0d err=%0d, expected 2 0", pkt_count, err_count);
        end
    endtask

    task automatic test_mid_reset();
        s2c_pkt_t p;
        bit       ok;
        clear_queues();
        p = rand_pkt(1'b1);
        offer(p, ok);
        drain(5, 0);
        tests_run++;
        if (!ok || out_valid !== 1'b1 || out_data !== p.data[3]) begin
            tests_failed++;
            $display("FAIL midrst_pre: got accepted=%b valid=%b data=%h, expected 1 1 %h",
                     ok, out_valid, out_data, p.data[3]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0 ||
            pkt_count !== 16'd0 || err_count !== 16'd0 || end_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_zero: got valid=%b sop=%b last=%b data=%h pkt=%0d err=%0d end=%b, expected all zero",
                     out_valid, out_sop, out_last, out_data, pkt_count, err_count, end_seen);
        end
        rst = 1'b0;
        tests_run++;
        if (pkt_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_ready: got pkt_ready=%b, expected 1", pkt_ready);
        end
        clear_queues();
        exp_pkts = 0;
        exp_errs = 0;
        exp_end  = 1'b0;
        p = rand_pkt(1'b1);
        model_pkt(p);
        offer(p, ok);
        drain(exp_q.size(), 1);
        tests_run++;
        if (!ok || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL midrst_len: got accepted=%b words=%0d, expected 1 %0d", ok, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL midrst_word%0d: got %h/%b/%b, expected %h/%b/%b", i, got_q[i].data,
                         got_q[i].sop, got_q[i].last, exp_q[i].data, exp_q[i].sop, exp_q[i].last);
            end
        end
        tests_run++;
        if (pkt_count !== 16'(exp_pkts) || err_count !== 16'(exp_errs)) begin
            tests_failed++;
            $display("FAIL midrst_counts: got pkt=%0d err=%0d, expected %0d %0d",
                     pkt_count, err_count, exp_pkts, exp_errs);
        end
    endtask

    task automatic test_end_error();
        s2c_pkt_t p;
        bit       ok;
        apply_reset();
        p         = rand_pkt(1'b0);
        p.hdr.fn  = FN_END;
        p.hdr.ret = -32'sd5;
        model_pkt(p);
        offer(p, ok);
        drain(exp_q.size(), 0);
        tests_run++;
        if (!ok || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL enderr_len: got accepted=%b words=%0d, expected 1 %0d", ok, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL enderr_word%0d: got %h/%b/%b, expected %h/%b/%b", i, got_q[i].data,
                         got_q[i].sop, got_q[i].last, exp_q[i].data, exp_q[i].sop, exp_q[i].last);
            end
        end
        tests_run++;
        if (pkt_count !== 16'(exp_pkts) || err_count !== 16'(exp_errs) || end_seen !== exp_end ||
            pkt_ready !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL enderr_status: got pkt=%0d err=%0d end=%b ready=%b valid=%b, expected %0d %0d %b 0 0",
                     pkt_count, err_count, end_seen, pkt_ready, out_valid, exp_pkts, exp_errs, exp_end);
        end
    endtask

    task automatic test_end();
        s2c_pkt_t p;
        bit       ok;
        int       busy;
        apply_reset();
        p        = rand_pkt(1'b1);
        p.hdr.id = 32'd0;
        p.hdr.fn = FN_END;
        model_pkt(p);
        offer(p, ok);
        drain(exp_q.size(), 0);
        tests_run++;
        if (!ok || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL end_len: got accepted=%b words=%0d, expected 1 %0d", ok, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL end_word%0d: got %h/%b/%b, expected %h/%b/%b", i, got_q[i].data,
                         got_q[i].sop, got_q[i].last, exp_q[i].data, exp_q[i].sop, exp_q[i].last);
            end
        end
        tests_run++;
        if (end_seen !== 1'b1 || pkt_ready !== 1'b0 || pkt_count !== 16'd1 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL end_status: got end=%b ready=%b pkt=%0d err=%0d, expected 1 0 1 0",
                     end_seen, pkt_ready, pkt_count, err_count);
        end
        p         = rand_pkt(1'b1);
        pkt_id    = p.hdr.id;
        pkt_fn    = p.hdr.fn;
        pkt_ret   = p.hdr.ret;
        pkt_data  = p.data;
        pkt_valid = 1'b1;
        busy      = 0;
        for (int i = 0; i < 20; i++) begin
            if (pkt_ready !== 1'b0 || out_valid !== 1'b0) busy++;
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
        tests_run++;
        if (busy != 0 || got_q.size() != exp_q.size() || pkt_count !== 16'd1 || end_seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL end_ignore: got active_cycles=%0d words=%0d pkt=%0d end=%b, expected 0 %0d 1 1",
                     busy, got_q.size(), pkt_count, end_seen, exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        pkt_valid = 1'b0;
        out_ready = 1'b1;
        pkt_id    = '0;
        pkt_fn    = '0;
        pkt_ret   = '0;
        pkt_data  = '0;
        exp_pkts  = 0;
        exp_errs  = 0;
        exp_end   = 1'b0;

        test_reset();
        test_normal();
        test_error();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_end_error();
        test_end();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
